// File: rtl/alu_seq.sv
// Registered ALU: 16 single-cycle ops, ADC/SBC, and iterative MUL/MULH/DIVU/REMU
// behind a valid/ready handshake. Flags are {Z,C,S,O}.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       mode,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             is_iter;
  logic [SHW-1:0]   amt;
  logic [CW-1:0]    amt_inv;
  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic             acin;
  logic             arith;
  logic [WIDTH-1:0] lres;
  logic [WIDTH:0]   asum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             mul_ovf;
  logic [WIDTH-1:0] iter_res;
  logic [3:0]       iter_flags;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign is_iter  = (mode[4:2] == 3'b100);
  assign amt      = operand1[SHW-1:0];
  assign amt_inv  = CW'(WIDTH) - {1'b0, amt};

  // Every add/sub form is X + Y' + cin over WIDTH+1 bits; non-arithmetic ops use lres.
  always_comb begin
    ax    = '0;
    ay    = '0;
    acin  = 1'b0;
    arith = 1'b1;
    lres  = '0;
    case (mode)
      5'h00: begin ax = operand1; ay = operand2; end
      5'h01: begin ax = operand1; ay = ~operand2; acin = 1'b1; end
      5'h07: begin ax = operand2; ay = ~operand1; acin = 1'b1; end
      5'h08: begin ax = operand2; ay = WIDTH'(1); end
      5'h09: begin ax = operand2; ay = ~WIDTH'(1); acin = 1'b1; end
      5'h0F: begin ax = '0; ay = ~operand2; acin = 1'b1; end
      5'h14: begin ax = operand1; ay = operand2; acin = carry_in; end
      5'h15: begin ax = operand1; ay = ~operand2; acin = carry_in; end
      5'h02: begin arith = 1'b0; lres = operand1; end
      5'h04: begin arith = 1'b0; lres = operand1 & operand2; end
      5'h05: begin arith = 1'b0; lres = operand1 | operand2; end
      5'h06: begin arith = 1'b0; lres = operand1 ^ operand2; end
      5'h0A: begin arith = 1'b0; lres = (operand2 << amt) | (operand2 >> amt_inv); end
      5'h0B: begin arith = 1'b0; lres = (operand2 >> amt) | (operand2 << amt_inv); end
      5'h0C: begin arith = 1'b0; lres = operand2 << amt; end
      5'h0D: begin arith = 1'b0; lres = operand2 >> amt; end
      5'h0E: begin arith = 1'b0; lres = $signed(operand2) >>> amt; end
      default: begin arith = 1'b0; lres = operand2; end
    endcase
    asum      = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
    alu_res   = arith ? asum[WIDTH-1:0] : lres;
    alu_flags = {alu_res == '0,
                 arith & asum[WIDTH],
                 alu_res[WIDTH-1],
                 arith & (ax[WIDTH-1] == ay[WIDTH-1]) & (asum[WIDTH-1] != ax[WIDTH-1])};
  end

  // One iteration step: shift-add multiply (acc_lo holds the multiplier, then the low
  // product) or restoring division (acc_lo shifts the dividend out and quotient bits in).
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    div_rem  = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = div_rem >= {1'b0, b_q};
    div_diff = div_rem[WIDTH-1:0] - b_q;
    if (!op_q[1]) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_diff : div_rem[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], div_ge};
    end
    cnt_n      = cnt + CW'(1);
    mul_ovf    = (hi_n != '0);
    iter_res   = op_q[0] ? hi_n : lo_n;
    iter_flags = {iter_res == '0,
                  ~op_q[1] & mul_ovf,
                  iter_res[WIDTH-1],
                  op_q[1] ? (b_q == '0) : mul_ovf};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      flags     <= '0;
      cnt       <= '0;
      op_q      <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else if (in_valid && in_ready) begin
      cnt <= '0;
      if (is_iter) begin
        state     <= BUSY;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        op_q      <= mode[1:0];
        b_q       <= operand2;
        acc_hi    <= '0;
        acc_lo    <= operand1;
      end else begin
        state     <= DONE;
        busy      <= 1'b0;
        out_valid <= 1'b1;
        result    <= alu_res;
        flags     <= alu_flags;
      end
    end else begin
      case (state)
        BUSY: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt_n;
          // The final iteration's outcome is registered straight into result/flags.
          if (cnt_n == CW'(WIDTH)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= iter_res;
            flags     <= iter_flags;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vector table, randomized ops against an
// arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_alu_seq;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] mode;
  logic       carry_in;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .carry_in(carry_in), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model in plain integer arithmetic; flags {Z,C,S,O}.
  function automatic void model(input logic [4:0] m, input int a, input int b, input bit c,
                                output logic [7:0] r, output logic [3:0] f, output int lat);
    int  u, s, x, y, ci, n, rr;
    bit  cf, of, is_add, is_sub;
    u = 0; x = 0; y = 0; ci = 0; cf = 0; of = 0; is_add = 0; is_sub = 0; lat = 1;
    n = a & 7;
    case (m)
      5'h00: begin is_add = 1; x = a; y = b; ci = 0; end
      5'h01: begin is_sub = 1; x = a; y = b; ci = 1; end
      5'h02: u = a;
      5'h03: u = b;
      5'h04: u = a & b;
      5'h05: u = a | b;
      5'h06: u = a ^ b;
      5'h07: begin is_sub = 1; x = b; y = a; ci = 1; end
      5'h08: begin is_add = 1; x = b; y = 1; ci = 0; end
      5'h09: begin is_sub = 1; x = b; y = 1; ci = 1; end
      5'h0A: u = (b << n) | (b >> (8 - n));
      5'h0B: u = (b >> n) | (b << (8 - n));
      5'h0C: u = b << n;
      5'h0D: u = b >> n;
      5'h0E: u = sx(b) >>> n;
      5'h0F: begin is_sub = 1; x = 0; y = b; ci = 1; end
      5'h10: begin u = a * b; cf = ((a * b) >> 8) != 0; of = cf; lat = 9; end
      5'h11: begin u = (a * b) >> 8; cf = u != 0; of = cf; lat = 9; end
      5'h12: begin lat = 9; if (b == 0) begin u = 255; of = 1; end else u = a / b; end
      5'h13: begin lat = 9; if (b == 0) begin u = a; of = 1; end else u = a % b; end
      5'h14: begin is_add = 1; x = a; y = b; ci = int'(c); end
      5'h15: begin is_sub = 1; x = a; y = b; ci = int'(c); end
      default: u = b;
    endcase
    if (is_add) begin
      u = x + y + ci; cf = u > 255;
      s = sx(x) + sx(y) + ci; of = (s > 127) || (s < -128);
    end
    if (is_sub) begin
      u = x - y - (1 - ci); cf = u >= 0;
      s = sx(x) - sx(y) - (1 - ci); of = (s > 127) || (s < -128);
    end
    rr = u & 255;
    r = rr[7:0];
    f = {rr == 0, cf, ((rr >> 7) & 1) == 1, of};
  endfunction

  // Issues one request (waiting for in_ready), scrambles the inputs after acceptance,
  // and measures edges from acceptance to out_valid plus cycles busy was seen high.
  task automatic do_op(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic c, output logic [7:0] r, output logic [3:0] f,
                       output int lat, output int bcnt);
    int guard;
    guard = 0;
    out_ready = 1'b1;
    #0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
    mode = m; operand1 = a; operand2 = b; carry_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = 5'($urandom); operand1 = 8'($urandom); operand2 = 8'($urandom);
    carry_in = 1'($urandom);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 50) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    r = result; f = flags;
  endtask

  logic [7:0] r, er;
  logic [3:0] f, ef;
  int         lat, elat, bc, ov_seen;
  logic [4:0] m;
  logic [7:0] a, b;
  logic       c;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0;
    operand1 = '0; operand2 = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset result", 32'(result), 0);
    chk("reset flags", 32'(flags), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    tbl.push_back('{5'h00, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1});
    tbl.push_back('{5'h01, 8'h05, 8'h05, 1'b0, 8'h00, 4'b1100, 1});
    tbl.push_back('{5'h14, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100, 1});
    tbl.push_back('{5'h15, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0010, 1});
    tbl.push_back('{5'h0A, 8'h03, 8'h81, 1'b0, 8'h0C, 4'b0000, 1});
    tbl.push_back('{5'h0E, 8'h01, 8'h80, 1'b0, 8'hC0, 4'b0010, 1});
    tbl.push_back('{5'h0C, 8'h00, 8'h5A, 1'b0, 8'h5A, 4'b0000, 1});
    tbl.push_back('{5'h0B, 8'h08, 8'h96, 1'b0, 8'h96, 4'b0010, 1});
    tbl.push_back('{5'h0F, 8'h00, 8'h80, 1'b0, 8'h80, 4'b0011, 1});
    tbl.push_back('{5'h09, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0010, 1});
    tbl.push_back('{5'h08, 8'h00, 8'h7F, 1'b0, 8'h80, 4'b0011, 1});
    tbl.push_back('{5'h00, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100, 1});
    tbl.push_back('{5'h16, 8'h55, 8'h00, 1'b1, 8'h00, 4'b1000, 1});
    tbl.push_back('{5'h10, 8'h20, 8'h10, 1'b0, 8'h00, 4'b1101, 9});
    tbl.push_back('{5'h11, 8'h20, 8'h10, 1'b0, 8'h02, 4'b0101, 9});
    tbl.push_back('{5'h12, 8'h64, 8'h07, 1'b0, 8'h0E, 4'b0000, 9});
    tbl.push_back('{5'h13, 8'h64, 8'h07, 1'b0, 8'h02, 4'b0000, 9});
    tbl.push_back('{5'h12, 8'h64, 8'h00, 1'b0, 8'hFF, 4'b0011, 9});
    tbl.push_back('{5'h13, 8'h64, 8'h00, 1'b0, 8'h64, 4'b0001, 9});

    foreach (tbl[i]) begin
      do_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].cin, r, f, lat, bc);
      chk($sformatf("tbl%0d mode=%0h result", i, tbl[i].mode), 32'(r), 32'(tbl[i].res));
      chk($sformatf("tbl%0d mode=%0h flags", i, tbl[i].mode), 32'(f), 32'(tbl[i].flg));
      chk($sformatf("tbl%0d mode=%0h latency", i, tbl[i].mode), lat, tbl[i].lat);
      chk($sformatf("tbl%0d mode=%0h busy_cycles", i, tbl[i].mode), bc,
          (tbl[i].lat == 9) ? 8 : 0);
    end

    for (int i = 0; i < 200; i++) begin
      m = 5'($urandom_range(0, 31));
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      model(m, int'(a), int'(b), c, er, ef, elat);
      do_op(m, a, b, c, r, f, lat, bc);
      chk($sformatf("rand m=%0h a=%0h b=%0h c=%0d result", m, a, b, c), 32'(r), 32'(er));
      chk($sformatf("rand m=%0h a=%0h b=%0h c=%0d flags", m, a, b, c), 32'(f), 32'(ef));
      chk($sformatf("rand m=%0h latency", m), lat, elat);
    end

    // Backpressure: result held while out_ready is low; a pending request is not taken.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    mode = 5'h00; operand1 = 8'h30; operand2 = 8'h12; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    mode = 5'h01; operand1 = 8'h05; operand2 = 8'h05;
    chk("bp first out_valid", 32'(out_valid), 1);
    chk("bp first result", 32'(result), 32'h42);
    chk("bp first flags", 32'(flags), 32'b0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 1);
      chk($sformatf("bp hold%0d result", k), 32'(result), 32'h42);
      chk($sformatf("bp hold%0d flags", k), 32'(flags), 32'b0000);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next out_valid", 32'(out_valid), 1);
    chk("bp next result", 32'(result), 32'h00);
    chk("bp next flags", 32'(flags), 32'b1100);

    // Reset during the fourth BUSY cycle of a division abandons it.
    do_op(5'h00, 8'h10, 8'h20, 1'b0, r, f, lat, bc);
    chk("pre-reset add result", 32'(r), 32'h30);
    mode = 5'h12; operand1 = 8'h64; operand2 = 8'h07; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div busy", 32'(busy), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst result", 32'(result), 0);
    chk("midrst flags", 32'(flags), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst busy", 32'(busy), 0);
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("midrst no stray output", ov_seen, 0);
    do_op(5'h00, 8'h01, 8'h02, 1'b0, r, f, lat, bc);
    chk("post-reset add result", 32'(r), 32'h03);
    chk("post-reset add flags", 32'(f), 32'b0000);
    chk("post-reset add latency", lat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the microcontroller's combinational ALU.
- Executes the existing 16 single-cycle operations at WIDTH bits, with the result and flags registered.
- Adds add/subtract-with-carry and iterative multiply/divide, behind a valid/ready handshake.
- Sits between the register file / operand muxes and the status register / DMem write path; the control unit drives the request side.

Parameters:
WIDTH, 8, datapath width in bits (≥4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
mode  in  5  operation select
carry_in  in  1  current C flag from status register (ADC/SBC only)
operand1  in  WIDTH  operand A
operand2  in  WIDTH  operand B
out_valid  out  1  result/flags valid; held until out_ready
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flags  out  4  registered {Z,C,S,O}
busy  out  1  high in BUSY state

Behaviour:
- Request is accepted on a clk edge with in_valid && in_ready. Operands and mode are captured at acceptance; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle operations at one per clock.
- States:
  - IDLE: on accept, go to DONE (single-cycle op) or BUSY (mode 0x10–0x13).
  - BUSY: runs exactly WIDTH iterations, then goes to DONE.
  - DONE: out_valid=1. If out_ready && !in_valid, go to IDLE. If out_ready && in_valid, perform a new accept (as from IDLE).
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops; WIDTH+1 cycles for iterative ops.
- result and flags are stable while out_valid && !out_ready.
- Reset (synchronous): state=IDLE, out_valid=0, busy=0, result=0, flags=0, iteration counter=0. Reset mid-BUSY abandons the operation with no output.
- Mode map (A=operand1, B=operand2):
  - 0x00 ADD A+B
  - 0x01 SUB A−B
  - 0x02 MOVA
  - 0x03 MOVB
  - 0x04 AND
  - 0x05 OR
  - 0x06 XOR
  - 0x07 RSUB B−A
  - 0x08 INC B+1
  - 0x09 DEC B−1
  - 0x0A ROL B by A[SHW-1:0]
  - 0x0B ROR
  - 0x0C SHL
  - 0x0D SHR (logical)
  - 0x0E ASR (sign-filling)
  - 0x0F NEG 0−B
  - 0x10 MUL (low half)
  - 0x11 MULH (high half, unsigned)
  - 0x12 DIVU quotient
  - 0x13 REMU remainder
  - 0x14 ADC A+B+carry_in
  - 0x15 SBC A−B−!carry_in
  - 0x16–0x1F: MOVB with flags Z/S updated and C=O=0
- Arithmetic:
  - All add/sub forms are computed in WIDTH+1 bits as X + Y' + cin, where Y' is either Y or ~Y.
  - C = bit WIDTH of that sum. For subtraction, C=1 means no borrow (X≥Y unsigned, including Y=0).
  - O = (X[msb]==Y'[msb]) && (sum[msb]!=X[msb]).
  - INC and DEC are ADD of 1 and SUB of 1 respectively; NEG is SUB with X=0.
- Flags:
  - Z = (result==0) and S = result[msb], for all ops.
  - Logic, move, rotate and shift ops: C=0, O=0. Shift by 0 returns B unchanged.
  - MUL/MULH: C=O=(product high half != 0).
  - DIVU/REMU with B≠0: C=0, O=0.
  - Division by zero: quotient = all ones, remainder = A, O=1, C=0. It still takes WIDTH+1 cycles.
- Iterative engine:
  - MUL is shift-add over a 2·WIDTH accumulator, one bit per cycle.
  - DIVU is restoring division, one quotient bit per cycle.
  - Counter width SHW+1; terminates when it reaches WIDTH.

Test Plan:
- ADD A=0x7F, B=0x01 (WIDTH=8) -> out_valid 1 cycle after accept, result=0x80, flags=4'b0011; SUB A=0x05, B=0x05 -> 0x00, flags=4'b1100.
- ADC A=0xFF, B=0x00, carry_in=1 -> 0x00, flags=4'b1100; SBC A=0x00, B=0x00, carry_in=0 -> 0xFF, flags=4'b0010.
- ROL A=3, B=0x81 -> 0x0C; ASR A=1, B=0x80 -> 0xC0, flags=4'b0010; SHL A=0, B=0x5A -> 0x5A.
- MUL A=0x20, B=0x10 -> out_valid exactly 9 cycles after accept, busy high 8 cycles, result=0x00, flags=4'b1101; MULH same operands -> 0x02.
- DIVU A=0x64, B=0x07 -> 0x0E; REMU -> 0x02; DIVU A=0x64, B=0x00 -> 0xFF with O=1; REMU A=0x64, B=0x00 -> 0x64.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles after an ADD result -> result/flags stable, in_ready=0. Raising out_ready with in_valid asserted accepts the next op that same edge; the next result is valid 1 cycle later.
  - Assert rst on BUSY cycle 4 of DIVU -> next cycle state IDLE, out_valid=0, result=0, flags=0, in_ready=1. A following ADD 0x01+0x02 returns 0x03.
